// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the fetch stage and the decoder.
// Holds architectural widths, opcode constants and the fetch queue entry type.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            filled;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Instruction fetches are always word aligned; the low two bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of fetch entries: allocated at request time, filled in order
// by memory responses, popped by decode. Flush empties it in one cycle.
module fetch_queue
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         alloc,
  input  logic [XLEN-1:0]              alloc_pc,
  input  logic                         fill,
  input  logic [ILEN-1:0]              fill_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic                         head_filled,
  output logic [XLEN-1:0]              head_pc,
  output logic [ILEN-1:0]              head_instr,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  entries_r [DEPTH];
  logic [PW-1:0] head_ptr_r;
  logic [PW-1:0] tail_ptr_r;
  logic [PW-1:0] fill_ptr_r;
  logic [CW-1:0] count_r;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    if (ptr == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return ptr + PW'(1'b1);
    end
  endfunction

  // Entry storage, pointers and occupancy; flush overrides every other update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr_r <= {PW{1'b0}};
      tail_ptr_r <= {PW{1'b0}};
      fill_ptr_r <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= '{pc: {XLEN{1'b0}}, filled: 1'b0, instr: {ILEN{1'b0}}};
      end
    end else if (flush) begin
      head_ptr_r <= {PW{1'b0}};
      tail_ptr_r <= {PW{1'b0}};
      fill_ptr_r <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i].filled <= 1'b0;
      end
    end else begin
      if (alloc) begin
        entries_r[tail_ptr_r] <= '{pc: alloc_pc, filled: 1'b0, instr: NOP_INSTR};
        tail_ptr_r            <= ptr_inc(tail_ptr_r);
      end
      // Fill and pop never target the same entry: pop needs it filled, fill needs it empty.
      if (fill) begin
        entries_r[fill_ptr_r].filled <= 1'b1;
        entries_r[fill_ptr_r].instr  <= fill_data;
        fill_ptr_r                   <= ptr_inc(fill_ptr_r);
      end
      if (pop) begin
        entries_r[head_ptr_r].filled <= 1'b0;
        head_ptr_r                   <= ptr_inc(head_ptr_r);
      end
      case ({alloc, pop})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head view is zeroed unless the head holds a returned instruction.
  always_comb begin
    head_filled = entries_r[head_ptr_r].filled;
    if (head_filled) begin
      head_pc    = entries_r[head_ptr_r].pc;
      head_instr = entries_r[head_ptr_r].instr;
    end else begin
      head_pc    = {XLEN{1'b0}};
      head_instr = {ILEN{1'b0}};
    end
  end

  assign count = count_r;

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: owns the PC, issues in-order word requests,
// and hands returned words to decode; redirects flush and drop stale responses.
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc_r;
  logic [CW-1:0]   drop_cnt_r;
  logic [CW-1:0]   pend_r;
  logic [CW-1:0]   count_s;
  logic [CW:0]     inflight_s;
  logic [CW:0]     outstanding_s;
  logic            req_fire_s;
  logic            rsp_drop_s;
  logic            rsp_fill_s;
  logic            pop_s;
  logic            head_filled_s;
  logic [XLEN-1:0] head_pc_s;
  logic [ILEN-1:0] head_instr_s;

  // Credit check, handshake decode and response steering.
  always_comb begin
    inflight_s    = {1'b0, count_s} + {1'b0, drop_cnt_r};
    outstanding_s = {1'b0, pend_r} + {1'b0, drop_cnt_r};
    if (rst_n && !redirect_valid && (inflight_s < (CW+1)'(DEPTH))) begin
      imem_req_valid = 1'b1;
    end else begin
      imem_req_valid = 1'b0;
    end
    req_fire_s = imem_req_valid && imem_req_ready;
    rsp_drop_s = imem_rsp_valid && (drop_cnt_r != {CW{1'b0}});
    rsp_fill_s = imem_rsp_valid && (drop_cnt_r == {CW{1'b0}}) && !redirect_valid;
    pop_s      = head_filled_s && instr_ready && !redirect_valid;
  end

  // PC, live-pending and drop counters; a redirect overrides all other updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r <= word_align(RESET_PC);
      drop_cnt_r <= {CW{1'b0}};
      pend_r     <= {CW{1'b0}};
    end else if (redirect_valid) begin
      fetch_pc_r <= word_align(redirect_pc);
      pend_r     <= {CW{1'b0}};
      // The response landing this cycle is already accounted for by being dropped now.
      if (imem_rsp_valid && (outstanding_s != {(CW+1){1'b0}})) begin
        drop_cnt_r <= CW'(outstanding_s - (CW+1)'(1'b1));
      end else begin
        drop_cnt_r <= CW'(outstanding_s);
      end
    end else begin
      if (req_fire_s) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
      end
      if (rsp_drop_s) begin
        drop_cnt_r <= drop_cnt_r - CW'(1'b1);
      end
      case ({req_fire_s, rsp_fill_s})
        2'b10:   pend_r <= pend_r + CW'(1'b1);
        2'b01:   pend_r <= pend_r - CW'(1'b1);
        default: pend_r <= pend_r;
      endcase
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc       (req_fire_s),
    .alloc_pc    (fetch_pc_r),
    .fill        (rsp_fill_s),
    .fill_data   (imem_rsp_data),
    .pop         (pop_s),
    .flush       (redirect_valid),
    .head_filled (head_filled_s),
    .head_pc     (head_pc_s),
    .head_instr  (head_instr_s),
    .count       (count_s)
  );

  // Decode-facing outputs come straight from queue storage.
  always_comb begin
    imem_req_addr = fetch_pc_r;
    instr_valid   = head_filled_s;
    instr         = head_instr_s;
    instr_pc      = head_pc_s;
    if (head_filled_s) begin
      instr_pc_plus4 = head_pc_s + 32'd4;
    end else begin
      instr_pc_plus4 = 32'd0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a memory model with configurable latency
// feeds the DUT while a scoreboard checks every instruction decode consumes.
module tb_fetch_unit;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] addr; int due; } mem_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc, instr_pc_plus4;

  logic        w_req_valid, w_req_ready, w_rsp_valid;
  logic [31:0] w_req_addr, w_rsp_data;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic        w_instr_valid, w_instr_ready;
  logic [31:0] w_instr, w_instr_pc, w_instr_pc_plus4;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .instr_valid(w_instr_valid), .instr_ready(w_instr_ready), .instr(w_instr),
    .instr_pc(w_instr_pc), .instr_pc_plus4(w_instr_pc_plus4)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   lat      = 1;
  exp_t exp_q[$];
  mem_t mem_q[$];
  exp_t w_exp_q[$];
  logic        w_pend;
  logic [31:0] w_pend_addr;

  logic        s_reqv, s_acc, s_pop, s_ivalid;
  logic [31:0] s_addr, s_instr, s_pc, s_pc4;
  logic        ws_acc, ws_pop;
  logic [31:0] ws_addr, ws_pop_pc, ws_pop_pc4;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] t;
    t = {a[15:0], a[31:16]} ^ 32'hC3A5_0F6B;
    return t;
  endfunction

  // One clock cycle: drive memory responses, sample, score, advance models.
  task automatic step();
    logic rsp_now;
    exp_t e;
    rsp_now = 1'b0;
    if (mem_q.size() > 0) rsp_now = (mem_q[0].due == cyc);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? mem_word(mem_q[0].addr) : 32'd0;
    w_rsp_valid    = w_pend;
    w_rsp_data     = w_pend ? mem_word(w_pend_addr) : 32'd0;
    #1;
    s_reqv   = imem_req_valid;
    s_addr   = imem_req_addr;
    s_acc    = imem_req_valid && imem_req_ready;
    s_ivalid = instr_valid;
    s_instr  = instr;
    s_pc     = instr_pc;
    s_pc4    = instr_pc_plus4;
    s_pop    = instr_valid && instr_ready;
    if (s_pop) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL decode_unexpected: got pc %h, required no instruction", instr_pc);
      end else begin
        e = exp_q.pop_front();
        if (instr !== e.instr || instr_pc !== e.pc || instr_pc_plus4 !== e.pc + 32'd4)
          $display("FAIL decode_entry: got %h/%h/%h, required %h/%h/%h",
                   instr, instr_pc, instr_pc_plus4, e.instr, e.pc, e.pc + 32'd4);
        else n_pass++;
      end
    end
    if (rsp_now) void'(mem_q.pop_front());
    if (redirect_valid) exp_q.delete();
    else if (s_acc) exp_q.push_back('{s_addr, mem_word(s_addr)});
    if (s_acc) mem_q.push_back('{s_addr, cyc + lat});

    ws_acc  = w_req_valid && w_req_ready;
    ws_addr = w_req_addr;
    ws_pop  = w_instr_valid && w_instr_ready;
    if (ws_pop) begin
      ws_pop_pc  = w_instr_pc;
      ws_pop_pc4 = w_instr_pc_plus4;
      n_checks++;
      if (w_exp_q.size() == 0) begin
        $display("FAIL wrap_decode_unexpected: got pc %h, required no instruction", w_instr_pc);
      end else begin
        e = w_exp_q.pop_front();
        if (w_instr !== e.instr || w_instr_pc !== e.pc || w_instr_pc_plus4 !== e.pc + 32'd4)
          $display("FAIL wrap_decode_entry: got %h/%h/%h, required %h/%h/%h",
                   w_instr, w_instr_pc, w_instr_pc_plus4, e.instr, e.pc, e.pc + 32'd4);
        else n_pass++;
      end
    end
    w_pend      = ws_acc;
    w_pend_addr = ws_addr;
    if (ws_acc) w_exp_q.push_back('{ws_addr, mem_word(ws_addr)});
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_models();
    mem_q.delete();
    exp_q.delete();
    w_exp_q.delete();
    w_pend = 1'b0;
    w_pend_addr = 32'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    clear_models();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (s_reqv !== 1'b0 || s_addr !== 32'd0 || s_ivalid !== 1'b0 ||
          s_instr !== 32'd0 || s_pc !== 32'd0 || s_pc4 !== 32'd0)
        $display("FAIL reset_outputs: got v=%b a=%h iv=%b i=%h pc=%h p4=%h, required all 0",
                 s_reqv, s_addr, s_ivalid, s_instr, s_pc, s_pc4);
      else n_pass++;
    end
    n_checks++;
    if (w_req_addr !== 32'hFFFF_FFF8)
      $display("FAIL reset_pc_param: got %h, required %h", w_req_addr, 32'hFFFF_FFF8);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_sequencing();
    logic [31:0] accs[$];
    logic [31:0] pops[$];
    logic [31:0] pop4s[$];
    int first_acc = -1;
    int first_pop = -1;
    lat = 1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (s_acc) begin accs.push_back(s_addr); if (first_acc < 0) first_acc = k; end
      if (s_pop) begin pops.push_back(s_pc); pop4s.push_back(s_pc4); if (first_pop < 0) first_pop = k; end
    end
    while (accs.size() < 3) accs.push_back(32'hDEAD_DEAD);
    while (pops.size() < 2) begin pops.push_back(32'hDEAD_DEAD); pop4s.push_back(32'hDEAD_DEAD); end
    n_checks++;
    if (first_acc !== 0) $display("FAIL first_request_cycle: got %0d, required 0", first_acc);
    else n_pass++;
    n_checks++;
    if ({accs[0], accs[1], accs[2]} !== {32'h0, 32'h4, 32'h8})
      $display("FAIL request_order: got %h %h %h, required 0 4 8", accs[0], accs[1], accs[2]);
    else n_pass++;
    n_checks++;
    if ({pops[0], pop4s[0], pops[1], pop4s[1]} !== {32'h0, 32'h4, 32'h4, 32'h8})
      $display("FAIL decode_order: got %h/%h %h/%h, required 0/4 4/8", pops[0], pop4s[0], pops[1], pop4s[1]);
    else n_pass++;
    n_checks++;
    if (first_pop - first_acc !== 2)
      $display("FAIL req_to_decode_latency: got %0d, required 2", first_pop - first_acc);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] accs[$];
    do_reset();
    lat = 1;
    instr_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin step(); if (s_acc) accs.push_back(s_addr); end
    n_checks++;
    if (accs.size() !== 2) $display("FAIL bp_request_count: got %0d, required 2", accs.size());
    else n_pass++;
    while (accs.size() < 2) accs.push_back(32'hDEAD_DEAD);
    n_checks++;
    if ({accs[0], accs[1]} !== {32'h0, 32'h4})
      $display("FAIL bp_request_addrs: got %h %h, required 0 4", accs[0], accs[1]);
    else n_pass++;
    n_checks++;
    if (s_reqv !== 1'b0) $display("FAIL bp_req_valid_low: got %b, required 0", s_reqv);
    else n_pass++;
    instr_ready = 1'b1;
    step();
    n_checks++;
    if (s_pop !== 1'b1 || s_pc !== 32'h0) $display("FAIL bp_pop: got pop=%b pc=%h, required pop=1 pc=0", s_pop, s_pc);
    else n_pass++;
    instr_ready = 1'b0;
    accs.delete();
    for (int k = 0; k < 5; k++) begin step(); if (s_acc) accs.push_back(s_addr); end
    n_checks++;
    if (accs.size() !== 1) $display("FAIL bp_reenable_count: got %0d, required 1", accs.size());
    else n_pass++;
    while (accs.size() < 1) accs.push_back(32'hDEAD_DEAD);
    n_checks++;
    if (accs[0] !== 32'h8) $display("FAIL bp_reenable_addr: got %h, required 8", accs[0]);
    else n_pass++;
    instr_ready = 1'b1;
  endtask

  task automatic test_mem_stall();
    logic [31:0] got;
    do_reset();
    lat = 1;
    instr_ready = 1'b1;
    imem_req_ready = 1'b1;
    step();
    step();
    imem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (s_addr !== 32'h8 || s_acc !== 1'b0)
        $display("FAIL stall_hold: got addr=%h acc=%b, required addr=8 acc=0", s_addr, s_acc);
      else n_pass++;
    end
    imem_req_ready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      got = 32'hDEAD_DEAD;
      for (int k = 0; k < 8; k++) begin
        step();
        if (s_acc) begin got = s_addr; break; end
      end
      n_checks++;
      if (got !== 32'h8 + 32'(n) * 32'd4)
        $display("FAIL stall_resume_%0d: got %h, required %h", n, got, 32'h8 + 32'(n) * 32'd4);
      else n_pass++;
    end
  endtask

  task automatic test_redirect_inflight();
    logic [31:0] acc_addr, pop_pc;
    do_reset();
    lat = 3;
    instr_ready = 1'b1;
    imem_req_ready = 1'b1;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    n_checks++;
    if (s_reqv !== 1'b0) $display("FAIL redir_no_req: got %b, required 0", s_reqv);
    else n_pass++;
    acc_addr = 32'hDEAD_DEAD;
    pop_pc = 32'hDEAD_DEAD;
    for (int k = 0; k < 20; k++) begin
      step();
      if (s_acc && acc_addr === 32'hDEAD_DEAD) acc_addr = s_addr;
      if (s_pop && pop_pc === 32'hDEAD_DEAD) pop_pc = s_pc;
    end
    n_checks++;
    if (acc_addr !== 32'h100) $display("FAIL redir_next_req: got %h, required 100", acc_addr);
    else n_pass++;
    n_checks++;
    if (pop_pc !== 32'h100) $display("FAIL redir_first_decode: got %h, required 100", pop_pc);
    else n_pass++;
  endtask

  task automatic test_redirect_same_cycle();
    logic [31:0] pop_pc;
    do_reset();
    lat = 1;
    instr_ready = 1'b1;
    imem_req_ready = 1'b1;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0202;
    step();
    redirect_valid = 1'b0;
    n_checks++;
    if (s_pop !== 1'b1 || s_pc !== 32'h0)
      $display("FAIL same_cycle_pop: got pop=%b pc=%h, required pop=1 pc=0", s_pop, s_pc);
    else n_pass++;
    step();
    n_checks++;
    if (s_ivalid !== 1'b0) $display("FAIL same_cycle_flushed: got instr_valid=%b, required 0", s_ivalid);
    else n_pass++;
    n_checks++;
    if (s_acc !== 1'b1 || s_addr !== 32'h200)
      $display("FAIL same_cycle_next_req: got acc=%b addr=%h, required acc=1 addr=200", s_acc, s_addr);
    else n_pass++;
    pop_pc = 32'hDEAD_DEAD;
    for (int k = 0; k < 8; k++) begin
      step();
      if (s_pop && pop_pc === 32'hDEAD_DEAD) pop_pc = s_pc;
    end
    n_checks++;
    if (pop_pc !== 32'h200) $display("FAIL same_cycle_first_decode: got %h, required 200", pop_pc);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] acc_addr, pop_pc;
    do_reset();
    lat = 1;
    instr_ready = 1'b1;
    imem_req_ready = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0300;
    step();
    n_checks++;
    if (s_reqv !== 1'b0) $display("FAIL b2b_first_no_req: got %b, required 0", s_reqv);
    else n_pass++;
    redirect_pc = 32'h0000_0400;
    step();
    redirect_valid = 1'b0;
    n_checks++;
    if (s_reqv !== 1'b0) $display("FAIL b2b_second_no_req: got %b, required 0", s_reqv);
    else n_pass++;
    acc_addr = 32'hDEAD_DEAD;
    pop_pc = 32'hDEAD_DEAD;
    for (int k = 0; k < 10; k++) begin
      step();
      if (s_acc && acc_addr === 32'hDEAD_DEAD) acc_addr = s_addr;
      if (s_pop && pop_pc === 32'hDEAD_DEAD) pop_pc = s_pc;
    end
    n_checks++;
    if (acc_addr !== 32'h400) $display("FAIL b2b_next_req: got %h, required 400", acc_addr);
    else n_pass++;
    n_checks++;
    if (pop_pc !== 32'h400) $display("FAIL b2b_first_decode: got %h, required 400", pop_pc);
    else n_pass++;
  endtask

  task automatic test_wrap_reset();
    logic [31:0] accs[$];
    logic [31:0] fc_pc4;
    do_reset();
    lat = 1;
    fc_pc4 = 32'hDEAD_DEAD;
    for (int k = 0; k < 6; k++) begin
      step();
      if (ws_acc) accs.push_back(ws_addr);
      if (ws_pop && ws_pop_pc === 32'hFFFF_FFFC) fc_pc4 = ws_pop_pc4;
    end
    while (accs.size() < 3) accs.push_back(32'hDEAD_DEAD);
    n_checks++;
    if ({accs[0], accs[1], accs[2]} !== {32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0})
      $display("FAIL wrap_requests: got %h %h %h, required fffffff8 fffffffc 0", accs[0], accs[1], accs[2]);
    else n_pass++;
    n_checks++;
    if (fc_pc4 !== 32'h0) $display("FAIL wrap_pc_plus4: got %h, required 0", fc_pc4);
    else n_pass++;

    do_reset();
    lat = 3;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0 || instr_valid !== 1'b0)
      $display("FAIL async_reset_main: got v=%b a=%h iv=%b, required 0/0/0", imem_req_valid, imem_req_addr, instr_valid);
    else n_pass++;
    n_checks++;
    if (w_req_addr !== 32'hFFFF_FFF8 || w_instr_valid !== 1'b0)
      $display("FAIL async_reset_wrap: got a=%h iv=%b, required fffffff8/0", w_req_addr, w_instr_valid);
    else n_pass++;
    clear_models();
    @(negedge clk);
    cyc++;
    step();
    rst_n = 1'b1;
    lat = 1;
    for (int n = 0; n < 2; n++) begin
      step();
      n_checks++;
      if (s_acc !== 1'b1 || s_addr !== 32'(n) * 32'd4)
        $display("FAIL post_reset_req_%0d: got acc=%b addr=%h, required acc=1 addr=%h", n, s_acc, s_addr, 32'(n) * 32'd4);
      else n_pass++;
    end
    for (int k = 0; k < 4; k++) step();
  endtask

  initial begin
    rst_n = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'd0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    instr_ready = 1'b1;
    w_req_ready = 1'b1;
    w_rsp_valid = 1'b0;
    w_rsp_data = 32'd0;
    w_redirect_valid = 1'b0;
    w_redirect_pc = 32'd0;
    w_instr_ready = 1'b1;
    w_pend = 1'b0;
    w_pend_addr = 32'd0;
    @(negedge clk);
    test_reset();
    test_sequencing();
    test_backpressure();
    test_mem_stall();
    test_redirect_inflight();
    test_redirect_same_cycle();
    test_back_to_back();
    test_wrap_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
